md5_crack_controller: RTL

Search sequencer for the MD5 cracker. It sweeps the guess length from MIN_LEN to MAX_LEN, restarts the guess generator for each length, and tracks which pipeline outputs carry valid guesses. It compares every valid hash against the target, captures the winning guess and length, then stops. It sits between the top level and the GuessGenerator / MD5Pipeline pair, replacing the hard-wired reset, charset and length logic.

---
 rtl/md5_crack_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/md5_crack_controller.sv
// Search sequencer for the MD5 cracker: sweeps guess lengths, restarts the generator per length,
// tracks valid pipeline slots, compares digests to the target and captures the first match.
module md5_crack_controller #(
    parameter int PIPE_DEPTH = 64,
    parameter int MIN_LEN    = 1,
    parameter int MAX_LEN    = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [2:0]   i_charset_in,
    input  logic [31:0]  i_target_a,
    input  logic [31:0]  i_target_b,
    input  logic [31:0]  i_target_c,
    input  logic [31:0]  i_target_d,
    output logic         o_gen_reset,
    output logic [2:0]   o_gen_charset,
    output logic [4:0]   o_guesslen,
    input  logic         i_gen_done,
    input  logic [127:0] i_guess,
    input  logic [31:0]  i_hash_a,
    input  logic [31:0]  i_hash_b,
    input  logic [31:0]  i_hash_c,
    input  logic [31:0]  i_hash_d,
    output logic         o_busy,
    output logic         o_found,
    output logic         o_exhausted,
    output logic [127:0] o_found_guess,
    output logic [4:0]   o_found_len,
    output logic [47:0]  o_tested
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_NEXT, S_FOUND, S_EXHAUSTED
    } state_t;

    localparam int            CW         = $clog2(PIPE_DEPTH + 2);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(PIPE_DEPTH);
    localparam logic [4:0]    MIN_L      = 5'(MIN_LEN);
    localparam logic [4:0]    MAX_L      = 5'(MAX_LEN);

    state_t          r_state;
    state_t          w_next;
    logic            r_post_reset;
    logic [127:0]    r_target;
    logic [2:0]      r_charset;
    logic [4:0]      r_guesslen;
    logic [CW-1:0]   r_drain_cnt;
    logic [128:0]    r_dl [PIPE_DEPTH];
    logic            r_match;
    logic            r_tail_valid;
    logic [127:0]    r_match_guess;
    logic [127:0]    r_found_guess;
    logic [4:0]      r_found_len;
    logic [47:0]     r_tested;

    logic            w_accept;
    logic            w_shift_valid;
    logic            w_hit;
    logic            w_searching;
    logic [128:0]    w_tail;

    assign w_accept      = i_start && (r_state == S_IDLE || r_state == S_FOUND || r_state == S_EXHAUSTED);
    assign w_shift_valid = (r_state == S_RUN);
    assign w_searching   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_tail        = r_dl[PIPE_DEPTH-1];
    assign w_hit         = w_tail[128] && ({i_hash_a, i_hash_b, i_hash_c, i_hash_d} == r_target);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FOUND, S_EXHAUSTED: if (i_start) w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN: begin
                if (r_match)         w_next = S_FOUND;
                else if (i_gen_done) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_match)                w_next = S_FOUND;
                else if (r_drain_cnt == '0) w_next = S_NEXT;
            end
            S_NEXT:  w_next = (r_guesslen == MAX_L) ? S_EXHAUSTED : S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Flushing on entry to LOAD keeps stale slots from a previous length or search out of the compare.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_next == S_LOAD) begin
            for (int i = 0; i < PIPE_DEPTH; i++) r_dl[i] <= '0;
            r_match       <= 1'b0;
            r_tail_valid  <= 1'b0;
            r_match_guess <= '0;
        end else begin
            r_dl[0] <= {w_shift_valid, i_guess};
            for (int i = 1; i < PIPE_DEPTH; i++) r_dl[i] <= r_dl[i-1];
            r_match       <= w_hit;
            r_tail_valid  <= w_tail[128];
            r_match_guess <= w_tail[127:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_post_reset  <= 1'b1;
            r_target      <= '0;
            r_charset     <= '0;
            r_guesslen    <= MIN_L;
            r_drain_cnt   <= '0;
            r_found_guess <= '0;
            r_found_len   <= '0;
            r_tested      <= '0;
        end else begin
            r_post_reset <= 1'b0;
            if (w_accept) begin
                r_target      <= {i_target_a, i_target_b, i_target_c, i_target_d};
                r_charset     <= i_charset_in;
                r_guesslen    <= MIN_L;
                r_tested      <= '0;
                r_found_guess <= '0;
                r_found_len   <= '0;
            end
            if (r_state == S_RUN && w_next == S_DRAIN)
                r_drain_cnt <= DRAIN_LOAD;
            else if (r_state == S_DRAIN && r_drain_cnt != '0)
                r_drain_cnt <= r_drain_cnt - CW'(1);
            if (r_state == S_NEXT && w_next == S_LOAD)
                r_guesslen <= r_guesslen + 5'd1;
            if (w_searching && r_tail_valid && r_tested != '1)
                r_tested <= r_tested + 48'd1;
            if (w_searching && w_next == S_FOUND) begin
                r_found_guess <= r_match_guess;
                r_found_len   <= r_guesslen;
            end
        end
    end

    assign o_gen_reset   = r_post_reset || (r_state == S_LOAD);
    assign o_gen_charset = r_charset;
    assign o_guesslen    = r_guesslen;
    assign o_busy        = (r_state == S_LOAD) || (r_state == S_RUN) ||
                           (r_state == S_DRAIN) || (r_state == S_NEXT);
    assign o_found       = (r_state == S_FOUND);
    assign o_exhausted   = (r_state == S_EXHAUSTED);
    assign o_found_guess = r_found_guess;
    assign o_found_len   = r_found_len;
    assign o_tested      = r_tested;

endmodule
